inv_mixcolumns: RTL and testbench

INV_MIXCOLUMNS -- requirements
Module: inv_mixcolumns

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/inv_mixcolumn_col.sv | 36 +++
 rtl/inv_mixcolumns.sv | 115 +++++++++++
 tb/tb_inv_mixcolumns.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the (inverse) MixColumns datapath.
// Column 0 occupies the top 32 bits of a state; row 0 is the top byte of a column.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Low byte of the AES field polynomial x^8+x^4+x^3+x+1.
  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
  endfunction

  // Constant multiply restricted to the coefficients MixColumns needs.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] x2;
    logic [7:0] x4;
    logic [7:0] x8;
    logic [7:0] r;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    case (c)
      8'h02:   r = x2;
      8'h03:   r = x2 ^ a;
      8'h09:   r = x8 ^ a;
      8'h0b:   r = x8 ^ x2 ^ a;
      8'h0d:   r = x8 ^ x4 ^ a;
      8'h0e:   r = x8 ^ x4 ^ x2;
      default: r = a;
    endcase
    return r;
  endfunction

  function automatic col_t col_get(input state_t s, input logic [1:0] idx);
    col_t c;
    case (idx)
      2'd0:    c = s[127:96];
      2'd1:    c = s[95:64];
      2'd2:    c = s[63:32];
      default: c = s[31:0];
    endcase
    return c;
  endfunction

  function automatic state_t col_put(input state_t s, input logic [1:0] idx, input col_t c);
    state_t r;
    r = s;
    case (idx)
      2'd0:    r[127:96] = c;
      2'd1:    r[95:64]  = c;
      2'd2:    r[63:32]  = c;
      default: r[31:0]   = c;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/inv_mixcolumn_col.sv
// Combinational transform of one 32-bit column (inverse MixColumns; forward when
// INV_MIXCOLUMNS_FWD_EN is defined and fwd=1).
module inv_mixcolumn_col
  import aes_pkg::*;
(
`ifdef INV_MIXCOLUMNS_FWD_EN
  input  logic fwd,
`endif
  input  col_t col_in,
  output col_t col_out
);

  logic [7:0] a    [4];
  logic [7:0] coef [4];
  logic [7:0] r    [4];

  // Row i uses the base coefficient row rotated right by i, so coef index is (j - i) mod 4.
  always_comb begin
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
`ifdef INV_MIXCOLUMNS_FWD_EN
    if (fwd) coef = '{8'h02, 8'h03, 8'h01, 8'h01};
`endif
    for (int i = 0; i < 4; i++) begin
      a[i] = col_in[31 - 8*i -: 8];
    end
    for (int i = 0; i < 4; i++) begin
      r[i] = 8'h00;
      for (int j = 0; j < 4; j++) begin
        r[i] = r[i] ^ gmul(a[j], coef[2'(j - i)]);
      end
    end
  end

  assign col_out = {r[0], r[1], r[2], r[3]};

endmodule

// File: rtl/inv_mixcolumns.sv
// Iterative AES inverse MixColumns over a 128-bit state, COLS_PER_CYCLE columns per cycle.
// Optional macro INV_MIXCOLUMNS_FWD_EN adds a per-transaction fwd select for forward MixColumns.
module inv_mixcolumns
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_MIXCOLUMNS_FWD_EN
  input  logic         fwd,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are both 1;
  // out_data/out_valid stay constant while out_valid=1 and out_ready=0.

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
    $error("inv_mixcolumns: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE % 4);
  localparam logic [1:0] LAST_IDX = 2'(4 - COLS_PER_CYCLE);

  fsm_e       fsm_state;
  state_t     st;
  state_t     st_upd;
  logic [1:0] col_idx;
  col_t       col_res [COLS_PER_CYCLE];
  logic       accept;

`ifdef INV_MIXCOLUMNS_FWD_EN
  logic fwd_q;
`endif

  for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
    col_t col_src;
    assign col_src = col_get(st, col_idx + 2'(k));
    inv_mixcolumn_col u_col (
`ifdef INV_MIXCOLUMNS_FWD_EN
      .fwd     (fwd_q),
`endif
      .col_in  (col_src),
      .col_out (col_res[k])
    );
  end

  always_comb begin
    st_upd = st;
    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
      st_upd = col_put(st_upd, col_idx + 2'(k), col_res[k]);
    end
  end

  // Gating with rst_n keeps in_ready low for the whole reset window.
  assign in_ready  = rst_n && ((fsm_state == IDLE) || ((fsm_state == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm_state == DONE);
  assign out_data  = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
      col_idx   <= 2'd0;
      st        <= '0;
`ifdef INV_MIXCOLUMNS_FWD_EN
      fwd_q     <= 1'b0;
`endif
    end else begin
      case (fsm_state)
        IDLE: begin
          if (accept) begin
            st        <= in_data;
            col_idx   <= 2'd0;
            fsm_state <= BUSY;
`ifdef INV_MIXCOLUMNS_FWD_EN
            fwd_q     <= fwd;
`endif
          end
        end
        BUSY: begin
          st      <= st_upd;
          col_idx <= col_idx + STEP;
          if (col_idx == LAST_IDX) fsm_state <= DONE;
        end
        DONE: begin
          // A new load here overlaps the outgoing handshake so results stream back to back.
          if (out_ready) begin
            if (accept) begin
              st        <= in_data;
              col_idx   <= 2'd0;
              fsm_state <= BUSY;
`ifdef INV_MIXCOLUMNS_FWD_EN
              fwd_q     <= fwd;
`endif
            end else begin
              fsm_state <= IDLE;
            end
          end
        end
        default: begin
          fsm_state <= IDLE;
          col_idx   <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_mixcolumns.sv
// Bench for inv_mixcolumns: three instances (1, 2, 4 columns per cycle), vector table,
// scoreboard queue, stall / streaming / reset-abort sequences.
module tb_inv_mixcolumns;

  logic         clk;
  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
`ifdef INV_MIXCOLUMNS_FWD_EN
  logic         fwd_sel;
`endif

  int n_checks = 0;
  int n_err    = 0;
  logic [127:0] exp_q[$];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int CPC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    inv_mixcolumns #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef INV_MIXCOLUMNS_FWD_EN
      .fwd       (fwd_sel),
`endif
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  localparam logic [7:0] INV_M [16] = '{8'h0e, 8'h0b, 8'h0d, 8'h09,
                                        8'h09, 8'h0e, 8'h0b, 8'h0d,
                                        8'h0d, 8'h09, 8'h0e, 8'h0b,
                                        8'h0b, 8'h0d, 8'h09, 8'h0e};
  localparam logic [7:0] FWD_M [16] = '{8'h02, 8'h03, 8'h01, 8'h01,
                                        8'h01, 8'h02, 8'h03, 8'h01,
                                        8'h01, 8'h01, 8'h02, 8'h03,
                                        8'h03, 8'h01, 8'h01, 8'h02};

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input bit f);
    logic [127:0] o;
    logic [7:0]   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gf_mul(s[127 - 32*c - 8*j -: 8], f ? FWD_M[r*4 + j] : INV_M[r*4 + j]);
        end
        o[127 - 32*c - 8*r -: 8] = acc;
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] rand_state();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Scoreboard: every output handshake pops the oldest expected result.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (rst_n === 1'b1 && out_valid[u] === 1'b1 && out_ready[u] === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL sb_unexpected: unit %0d produced %h, expected nothing", u, out_data[u]);
        end else begin
          check($sformatf("sb_unit%0d", u), out_data[u], exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input int u, input logic [127:0] din, input logic [127:0] exp,
                         input int exp_lat, input string name);
    int n;
    n = 0;
    while (in_ready[u] !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    if (in_ready[u] !== 1'b1) begin
      fail_timeout({name, "_accept"});
      return;
    end
    in_valid[u] = 1'b1;
    in_data[u]  = din;
    exp_q.push_back(exp);
    step();
    in_valid[u] = 1'b0;
    in_data[u]  = '0;
    check({name, "_busy_in_ready"}, 128'(in_ready[u]), 128'(0));
    n = 0;
    while (out_valid[u] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (out_valid[u] !== 1'b1) begin
      fail_timeout({name, "_out_valid"});
      return;
    end
    check({name, "_latency"}, 128'(n), 128'(exp_lat));
    check({name, "_data"}, out_data[u], exp);
    out_ready[u] = 1'b1;
    step();
    out_ready[u] = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int           unit;
    logic [127:0] din;
    logic [127:0] dout;
    int           lat;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] d;
    logic [127:0] e;
    logic [127:0] b2b_data [8];
    int           out_times [8];
    int           outs;
    int           idx;
    int           pulses;
    bit           taken;

    vecs[0] = '{0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 4};
    vecs[1] = '{0, 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff, 4};
    vecs[2] = '{1, 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff, 2};
    vecs[3] = '{2, 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff, 128'h2d26314c_d4d4d4d5_00000000_ffffffff, 1};
    vecs[4] = '{1, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 2};
    vecs[5] = '{2, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1};

    rst_n = 1'b0;
`ifdef INV_MIXCOLUMNS_FWD_EN
    fwd_sel = 1'b0;
`endif
    for (int u = 0; u < 3; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b0;
    end

    // Reset state
    step();
    step();
    for (int u = 0; u < 3; u++) begin
      check($sformatf("reset_out_valid_u%0d", u), 128'(out_valid[u]), 128'(0));
      check($sformatf("reset_in_ready_u%0d", u), 128'(in_ready[u]), 128'(0));
      check($sformatf("reset_out_data_u%0d", u), out_data[u], 128'(0));
    end
    rst_n = 1'b1;
    #1;
    for (int u = 0; u < 3; u++) begin
      check($sformatf("release_in_ready_u%0d", u), 128'(in_ready[u]), 128'(1));
    end

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i].unit, vecs[i].din, vecs[i].dout, vecs[i].lat, $sformatf("vec%0d", i));
    end

    // Random states on every width, checked against the model
    for (int u = 0; u < 3; u++) begin
      for (int i = 0; i < 2; i++) begin
        d = rand_state();
        run_txn(u, d, model(d, 1'b0), 4 / (1 << u), $sformatf("rand_u%0d_%0d", u, i));
      end
    end

    // Stall in DONE for 10 cycles
    d = rand_state();
    e = model(d, 1'b0);
    in_valid[0] = 1'b1;
    in_data[0]  = d;
    exp_q.push_back(e);
    step();
    in_data[0] = rand_state();
    for (int n = 0; n < 20 && out_valid[0] !== 1'b1; n++) step();
    for (int n = 0; n < 10; n++) begin
      check($sformatf("stall_data_%0d", n), out_data[0], e);
      check($sformatf("stall_valid_%0d", n), 128'(out_valid[0]), 128'(1));
      check($sformatf("stall_in_ready_%0d", n), 128'(in_ready[0]), 128'(0));
      step();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    step();

    // Back-to-back streaming: one result every 5 cycles
    for (int i = 0; i < 8; i++) b2b_data[i] = rand_state();
    outs = 0;
    idx  = 0;
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = b2b_data[0];
    for (int cyc = 0; cyc < 200 && outs < 8; cyc++) begin
      taken = (in_valid[0] === 1'b1 && in_ready[0] === 1'b1);
      if (taken) exp_q.push_back(model(in_data[0], 1'b0));
      step();
      if (taken) begin
        idx++;
        if (idx < 8) in_data[0] = b2b_data[idx];
        else in_valid[0] = 1'b0;
      end
      if (out_valid[0] === 1'b1) begin
        out_times[outs] = cyc;
        outs++;
      end
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b0;
    check("b2b_count", 128'(outs), 128'(8));
    if (outs == 8) begin
      check("b2b_first_latency", 128'(out_times[0]), 128'(4));
      for (int i = 1; i < 8; i++) begin
        check($sformatf("b2b_gap_%0d", i), 128'(out_times[i] - out_times[i-1]), 128'(5));
      end
    end
    step();

    // Reset during BUSY discards the transaction
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_data[0]   = rand_state();
    exp_q.push_back(model(in_data[0], 1'b0));
    step();
    in_valid[0] = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    exp_q.delete();
    check("abort_out_valid", 128'(out_valid[0]), 128'(0));
    check("abort_in_ready", 128'(in_ready[0]), 128'(0));
    check("abort_out_data", out_data[0], 128'(0));
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 8; n++) begin
      if (out_valid[0] !== 1'b0) pulses++;
      step();
    end
    check("abort_no_pulse", 128'(pulses), 128'(0));
    out_ready[0] = 1'b0;
    d = rand_state();
    run_txn(0, d, model(d, 1'b0), 4, "after_abort");

`ifdef INV_MIXCOLUMNS_FWD_EN
    fwd_sel = 1'b1;
    run_txn(0, 128'hdb135345_f20a225c_01010101_c6c6c6c6,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4, "fwd_vec");
    fwd_sel = 1'b0;
    run_txn(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
            128'hdb135345_f20a225c_01010101_c6c6c6c6, 4, "fwd_roundtrip");
    d = rand_state();
    fwd_sel = 1'b1;
    run_txn(2, d, model(d, 1'b1), 1, "fwd_rand_u2");
    fwd_sel = 1'b0;
`endif

    step();
    step();
    check("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
